// File: rtl/des_pkg.sv
// Shared DES types and constants: half-block and round-index types, P permutation table.
// Used by the S-box, key-schedule and round-combine stages.
package des_pkg;

    typedef logic [31:0] half_t;
    typedef logic [3:0]  round_t;

    localparam int     DES_NUM_ROUNDS = 16;
    localparam round_t DES_LAST_ROUND = round_t'(DES_NUM_ROUNDS - 1);

    // Entry k is the DES input bit feeding DES output bit k+1 (DES bit n lives at vector index 32-n).
    localparam int unsigned DES_P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    typedef struct packed {
        half_t  left;
        half_t  right;
        round_t round;
        logic   last;
    } round_res_t;

endpackage

// File: rtl/des_p_perm.sv
// Purely combinational DES P permutation of the 32-bit S-box output.
module des_p_perm
    import des_pkg::*;
(
    input  half_t din,
    output half_t dout
);

    for (genvar k = 0; k < 32; k++) begin : g_bit
        assign dout[31 - k] = din[32 - DES_P_TABLE[k]];
    end

endmodule

// File: rtl/des_round_combine.sv
// DES Feistel back end: f = P(sbox), L/R combine and swap, registered output with a one-entry skid.
// Optional macro DES_ROUND_SEQ_CHECK_EN builds the sticky round-sequence checker behind seq_err.
module des_round_combine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_NUM_ROUNDS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_sbox,
    input  logic [31:0] in_left,
    input  logic [31:0] in_right,
    input  logic [3:0]  in_round,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_left,
    output logic [31:0] out_right,
    output logic [3:0]  out_round,
    output logic        out_last,
    output logic        seq_err
);

    localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS - 1);

    half_t      f;
    round_res_t res;
    round_res_t out_q;
    round_res_t skid_q;
    logic       out_valid_q;
    logic       skid_full;
    logic       skid_full_d;
    logic       in_ready_q;
    logic       accept;
    logic       out_free;

    des_p_perm u_p_perm (
        .din  (in_sbox),
        .dout (f)
    );

    // Out-of-range round indices never match LAST_ROUND, so they take the swapping path.
    always_comb begin
        res       = '0;
        res.round = in_round;
        res.last  = (in_round == LAST_ROUND);
        if (res.last) begin
            res.left  = in_left ^ f;
            res.right = in_right;
        end else begin
            res.left  = in_right;
            res.right = in_left ^ f;
        end
    end

    assign accept      = in_valid && in_ready_q;
    assign out_free    = !out_valid_q || out_ready;
    assign skid_full_d = out_free ? 1'b0 : (skid_full || accept);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_full   <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            skid_full  <= skid_full_d;
            in_ready_q <= !skid_full_d;
            if (out_free) begin
                if (skid_full) begin
                    out_q       <= skid_q;
                    out_valid_q <= 1'b1;
                end else if (accept) begin
                    out_q       <= res;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    // NOTE: the skid payload has no reset; skid_full alone says whether it holds anything.
    always_ff @(posedge clk) begin
        if (accept && !out_free) begin
            skid_q <= res;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_left  = out_q.left;
    assign out_right = out_q.right;
    assign out_round = out_q.round;
    assign out_last  = out_q.last;

`ifdef DES_ROUND_SEQ_CHECK_EN
    round_t exp_round;
    logic   seq_err_q;

    function automatic round_t next_round(input round_t r);
        return (r == LAST_ROUND) ? round_t'(0) : round_t'(r + 1'b1);
    endfunction

    // A mismatch resyncs the expected counter to the observed round so one slip flags once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exp_round <= '0;
            seq_err_q <= 1'b0;
        end else if (accept) begin
            if (in_round != exp_round) begin
                seq_err_q <= 1'b1;
                exp_round <= next_round(in_round);
            end else begin
                exp_round <= next_round(exp_round);
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_round_combine.sv
// Self-checking bench for des_round_combine: directed vectors plus a randomized handshake run
// scored against a queue-based reference model.
module tb_des_round_combine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sbox;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic [3:0]  in_round;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_left;
    logic [31:0] out_right;
    logic [3:0]  out_round;
    logic        out_last;
    logic        seq_err;

`ifdef DES_ROUND_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [3:0]  rd;
        logic        last;
    } res_t;

    int n_pass  = 0;
    int n_total = 0;

    des_round_combine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sbox   (in_sbox),
        .in_left   (in_left),
        .in_right  (in_right),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .out_round (out_round),
        .out_last  (out_last),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // DES P permutation straight from the table: output bit pos takes input bit P[pos].
    function automatic logic [31:0] p_ref(input logic [31:0] s);
        int tbl [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                         2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
        logic [31:0] p = '0;
        for (int pos = 1; pos <= 32; pos++) p[32 - pos] = s[32 - tbl[pos - 1]];
        return p;
    endfunction

    function automatic res_t model(input logic [31:0] s, l, r, input logic [3:0] rd);
        res_t e;
        logic [31:0] f = p_ref(s);
        e.rd   = rd;
        e.last = (rd == 4'd15);
        if (e.last) begin e.l = l ^ f; e.r = r;     end
        else        begin e.l = r;     e.r = l ^ f; end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] s, l, r, input logic [3:0] rd);
        in_sbox  = s;
        in_left  = l;
        in_right = r;
        in_round = rd;
        in_valid = 1'b1;
    endtask

    task automatic check_out(input string tag, input res_t e);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_left"},  64'(out_left),  64'(e.l));
        check({tag, "_right"}, 64'(out_right), 64'(e.r));
        check({tag, "_round"}, 64'(out_round), 64'(e.rd));
        check({tag, "_last"},  64'(out_last),  64'(e.last));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        res_t        e;
        res_t        ea;
        res_t        eb;
        res_t        q[$];
        logic        exp_ready;
        logic        acc;
        logic        drn;
        logic [31:0] s, l, r;
        logic [3:0]  rd;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sbox   = '0;
        in_left   = '0;
        in_right  = '0;
        in_round  = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_left",  64'(out_left),  64'd0);
        check("rst_out_right", 64'(out_right), 64'd0);
        check("rst_out_round", 64'(out_round), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_seq_err",   64'(seq_err),   64'd0);
        reset_n = 1'b1;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming: rounds 0..15 back to back, one result per cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s = $urandom; l = $urandom; r = $urandom;
            drive(s, l, r, 4'(k));
            step();
            check_out("stream", model(s, l, r, 4'(k)));
        end
        in_valid = 1'b0;
        check("stream_seq_err", 64'(seq_err), 64'd0);
        step();
        check("stream_idle", 64'(out_valid), 64'd0);

        // Directed vectors with spec-given expected values.
        drive(32'h8000_0000, 32'h0, 32'h0, 4'd0);
        step();
        in_valid = 1'b0;
        check("pbit_left",  64'(out_left),  64'h0);
        check("pbit_right", 64'(out_right), 64'h0080_0000);

        drive(32'h5C82_B597, 32'hCC00_CCFF, 32'hF0AA_F0AA, 4'd0);
        step();
        in_valid = 1'b0;
        check("kv_left",  64'(out_left),  64'hF0AA_F0AA);
        check("kv_right", 64'(out_right), 64'hEF4A_6544);

        drive(32'h0, 32'hAAAA_AAAA, 32'h5555_5555, 4'd15);
        step();
        in_valid = 1'b0;
        check("final_left",  64'(out_left),  64'hAAAA_AAAA);
        check("final_right", 64'(out_right), 64'h5555_5555);
        check("final_last",  64'(out_last),  64'd1);

        drive(32'h0, 32'hAAAA_AAAA, 32'h5555_5555, 4'd3);
        step();
        in_valid = 1'b0;
        check("mid_left",  64'(out_left),  64'h5555_5555);
        check("mid_right", 64'(out_right), 64'hAAAA_AAAA);
        check("mid_last",  64'(out_last),  64'd0);
        step();

        // Backpressure: A sits in the output, B lands in the skid.
        out_ready = 1'b0;
        s = $urandom; l = $urandom; r = $urandom;
        ea = model(s, l, r, 4'd2);
        drive(s, l, r, 4'd2);
        step();
        check_out("bp_a", ea);
        check("bp_ready_a", 64'(in_ready), 64'd1);
        s = $urandom; l = $urandom; r = $urandom;
        eb = model(s, l, r, 4'd5);
        drive(s, l, r, 4'd5);
        step();
        in_valid = 1'b0;
        check("bp_ready_b", 64'(in_ready), 64'd0);
        check_out("bp_hold1", ea);
        step();
        check_out("bp_hold2", ea);
        check("bp_ready_hold", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check_out("bp_b", eb);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Sequence error, then reset in the middle of a stall.
        do_reset();
        drive(32'h1, 32'h2, 32'h3, 4'd0);
        step();
        drive(32'h1, 32'h2, 32'h3, 4'd1);
        step();
        check("seq_ok", 64'(seq_err), 64'd0);
        drive(32'h1, 32'h2, 32'h3, 4'd3);
        step();
        in_valid = 1'b0;
        check("seq_err_set", 64'(seq_err), 64'(SEQ_ON));
        step();
        check("seq_err_sticky", 64'(seq_err), 64'(SEQ_ON));
        out_ready = 1'b0;
        drive(32'h11, 32'h22, 32'h33, 4'd4);
        step();
        drive(32'h44, 32'h55, 32'h66, 4'd5);
        step();
        reset_n = 1'b0;
        step();
        check("mid_rst_valid",   64'(out_valid), 64'd0);
        check("mid_rst_seq_err", 64'(seq_err),   64'd0);
        check("mid_rst_ready",   64'(in_ready),  64'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        step();
        check("mid_rst_ready_up", 64'(in_ready),  64'd1);
        check("mid_rst_idle",     64'(out_valid), 64'd0);

        // Randomized handshakes against a two-deep occupancy model.
        exp_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            s  = $urandom; l = $urandom; r = $urandom;
            rd = 4'($urandom_range(0, 15));
            drive(s, l, r, rd);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            e   = model(s, l, r, rd);
            acc = in_valid && exp_ready;
            drn = (q.size() > 0) && out_ready;
            step();
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
            exp_ready = (q.size() < 2);
            check("rnd_in_ready", 64'(in_ready), 64'(exp_ready));
            if (q.size() > 0) check_out("rnd", q[0]);
            else check("rnd_valid", 64'(out_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
